// File: rtl/nic_common_pkg.sv
// rtl/nic_common_pkg.sv - shared NIC types and defaults
// Holds the edge_gen FSM state type and its default widths.
package nic_common_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} edge_gen_state_t;

  localparam int EG_CNT_WIDTH   = 8;
  localparam int EG_PULSE_WIDTH = 16;

endpackage

// File: rtl/edge_gen_if.sv
// rtl/edge_gen_if.sv - command and waveform bundle for edge_gen
// The master drives the train request; the slave (edge_gen) returns the waveform and status.
interface edge_gen_if #(
  parameter int CNT_WIDTH   = nic_common_pkg::EG_CNT_WIDTH,
  parameter int PULSE_WIDTH = nic_common_pkg::EG_PULSE_WIDTH
) ();

  logic                   start;
  logic                   stop;
  logic [CNT_WIDTH-1:0]   high_cycles;
  logic [CNT_WIDTH-1:0]   low_cycles;
  logic [PULSE_WIDTH-1:0] pulse_count;
  logic                   signal;
  logic                   pos_edge;
  logic                   neg_edge;
  logic                   busy;
  logic                   done;

  modport master (
    output start, stop, high_cycles, low_cycles, pulse_count,
    input  signal, pos_edge, neg_edge, busy, done
  );

  modport slave (
    input  start, stop, high_cycles, low_cycles, pulse_count,
    output signal, pos_edge, neg_edge, busy, done
  );

endinterface

// File: rtl/load_down_counter.sv
// rtl/load_down_counter.sv - loadable down-counter with zero flag
// Load wins over enable; the count holds at zero rather than wrapping.
module load_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/edge_gen.sv
// rtl/edge_gen.sv - programmable pulse-train generator
// HIGH/LOW phases are timed by a down-counter loaded with length-1; pulses are counted at each LOW end.
module edge_gen
  import nic_common_pkg::*;
#(
  parameter int CNT_WIDTH   = EG_CNT_WIDTH,
  parameter int PULSE_WIDTH = EG_PULSE_WIDTH
) (
  input  logic      clock,
  input  logic      reset,
  edge_gen_if.slave eg
);

  edge_gen_state_t        state_q;
  logic                   signal_q, pos_q, neg_q, busy_q, done_q, stop_q;
  logic [CNT_WIDTH-1:0]   high_m1_q, low_m1_q;
  logic [PULSE_WIDTH-1:0] target_q, pulses_q;

  logic                   ph_load, ph_zero;
  logic [CNT_WIDTH-1:0]   ph_value, ph_cnt;
  logic [CNT_WIDTH-1:0]   high_m1_in, low_m1_in;
  logic [PULSE_WIDTH-1:0] pulses_inc;
  logic                   finished;

  // Lengths 0 and 1 both map to a single-cycle phase.
  assign high_m1_in = (eg.high_cycles == '0) ? '0 : eg.high_cycles - 1'b1;
  assign low_m1_in  = (eg.low_cycles == '0) ? '0 : eg.low_cycles - 1'b1;
  assign pulses_inc = (pulses_q == '1) ? pulses_q : pulses_q + 1'b1;
  assign finished   = ((target_q != '0) && (pulses_inc == target_q)) || stop_q || eg.stop;

  always_comb begin
    ph_load  = 1'b0;
    ph_value = high_m1_q;
    case (state_q)
      IDLE: if (eg.start) begin
        ph_load  = 1'b1;
        ph_value = high_m1_in;
      end
      HIGH: if (ph_zero) begin
        ph_load  = 1'b1;
        ph_value = low_m1_q;
      end
      LOW: if (ph_zero && !finished) begin
        ph_load  = 1'b1;
        ph_value = high_m1_q;
      end
      default: ;
    endcase
  end

  load_down_counter #(.WIDTH(CNT_WIDTH)) u_phase_cnt (
    .clock        (clock),
    .reset        (reset),
    .load_i       (ph_load),
    .load_value_i (ph_value),
    .enable_i     (busy_q),
    .count_o      (ph_cnt),
    .zero_o       (ph_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      signal_q  <= 1'b0;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stop_q    <= 1'b0;
      high_m1_q <= '0;
      low_m1_q  <= '0;
      target_q  <= '0;
      pulses_q  <= '0;
    end else begin
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (eg.start) begin
          state_q   <= HIGH;
          signal_q  <= 1'b1;
          pos_q     <= 1'b1;
          busy_q    <= 1'b1;
          high_m1_q <= high_m1_in;
          low_m1_q  <= low_m1_in;
          target_q  <= eg.pulse_count;
          pulses_q  <= '0;
          stop_q    <= 1'b0;
        end
        HIGH: begin
          if (eg.stop) stop_q <= 1'b1;
          if (ph_zero) begin
            state_q  <= LOW;
            signal_q <= 1'b0;
            neg_q    <= 1'b1;
          end
        end
        LOW: begin
          if (eg.stop) stop_q <= 1'b1;
          if (ph_zero) begin
            pulses_q <= pulses_inc;
            if (finished) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              stop_q  <= 1'b0;
            end else begin
              state_q  <= HIGH;
              signal_q <= 1'b1;
              pos_q    <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eg.signal   = signal_q;
  assign eg.pos_edge = pos_q;
  assign eg.neg_edge = neg_q;
  assign eg.busy     = busy_q;
  assign eg.done     = done_q;

  a_high_cnt_bound: assert property (@(posedge clock) disable iff (!reset)
    (state_q == HIGH) |-> (ph_cnt <= high_m1_q));

endmodule
